// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
// Frame geometry, command codes and FSM state encodings.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

endpackage

// File: rtl/spi_master_shreg.sv
// MOSI parallel-load shift register and MISO capture register.
// The capture counter flags the eighth received bit.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [FRAME_W-1:0] ld_frame,
    input  logic              shift,
    input  logic              cap_en,
    input  logic              miso,
    output logic              mosi_bit,
    output logic              cap_last,
    output logic [DATA_W-1:0] cap_byte
);

    logic [FRAME_W-1:0] frame_q;
    logic [DATA_W-1:0]  cap_q;
    logic [3:0]         cap_cnt;

    assign mosi_bit = frame_q[FRAME_W-1];
    assign cap_last = cap_en && (cap_cnt == 4'(DATA_W - 1));
    assign cap_byte = {cap_q[DATA_W-2:0], miso};

    // Load a frame on launch, then move it out MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (load) begin
            frame_q <= ld_frame;
        end else if (shift) begin
            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
        end
    end

    // Collect MISO MSB first; the counter restarts whenever capture is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= '0;
            cap_cnt <= '0;
        end else if (cap_en) begin
            cap_q   <= cap_byte;
            cap_cnt <= cap_cnt + 4'd1;
        end else begin
            cap_cnt <= '0;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI RAM slave: 10-bit frames, optional read reply.
// SPI_MASTER_AUTO_RD_EN: rd-addr automatically chains a rd-data frame.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int GAP_CYC = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

    logic [2:0]         state;
    logic [3:0]         cnt;
    logic [1:0]         cmd_q;
    logic               auto_pend;
    logic               launch;
    logic               set_auto;
    logic               mosi_bit;
    logic               cap_last;
    logic [DATA_W-1:0]  cap_byte;
    logic [FRAME_W-1:0] ld_frame;

    assign cmd_ready = (state == ST_IDLE) && !auto_pend;
    assign busy      = (state != ST_IDLE) || auto_pend;
    assign launch    = (state == ST_IDLE) && (auto_pend || cmd_valid);
    assign ld_frame  = auto_pend ? {CMD_RD_DATA, 8'h00}
                                 : {cmd, cmd_data};

`ifdef SPI_MASTER_AUTO_RD_EN
    assign set_auto = !auto_pend && (cmd == CMD_RD_ADDR);
`else
    assign set_auto = 1'b0;
`endif

    spi_master_shreg u_shreg (
        .clk      (CLK),
        .rst      (rst),
        .load     (launch),
        .ld_frame (ld_frame),
        .shift    ((state == ST_START) || (state == ST_SHIFT)),
        .cap_en   (state == ST_RECV),
        .miso     (MISO),
        .mosi_bit (mosi_bit),
        .cap_last (cap_last),
        .cap_byte (cap_byte)
    );

    // Frame sequencer; SS_n and MOSI are registered with the next state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_q     <= '0;
            auto_pend <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state     <= ST_START;
                        cnt       <= '0;
                        cmd_q     <= ld_frame[FRAME_W-1 -: 2];
                        auto_pend <= set_auto;
                        SS_n      <= 1'b0;
                        MOSI      <= ld_frame[FRAME_W-1];
                    end
                end
                ST_START: begin
                    state <= ST_SHIFT;
                    cnt   <= '0;
                    MOSI  <= mosi_bit;
                end
                ST_SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (cmd_q == CMD_RD_DATA) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_END;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        MOSI <= mosi_bit;
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state <= ST_RECV;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RECV: begin
                    if (cap_last) begin
                        state     <= ST_END;
                        cnt       <= '0;
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_byte;
                    end
                end
                ST_END: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with an SPI RAM slave model.
// Frames and replies are predicted from the issued command stream.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int RD_WAIT = 2;
    localparam int GAP_CYC = 1;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    spi_master_ctrl #(.RD_WAIT(RD_WAIT), .GAP_CYC(GAP_CYC)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: RAM contents and address registers.
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_waddr = 8'h00;
    logic [7:0]  ref_raddr = 8'h00;
    logic [31:0] exp_bits [$];
    int          exp_len  [$];
    logic [7:0]  exp_rsp  [$];

    // Expected SS_n-low MOSI trace: frame[9], frame[9:0], then zeros.
    function automatic void push_frame(input logic [1:0] c,
                                       input logic [7:0] d);
        logic [9:0]  f;
        logic [31:0] b;
        int          n;
        f = {c, d};
        b = {21'b0, f[9], f};
        n = 11;
        if (c == 2'b11) begin
            n = 19 + RD_WAIT;
            b = b << (RD_WAIT + 8);
        end
        exp_bits.push_back(b);
        exp_len.push_back(n);
    endfunction

    function automatic void model(input logic [1:0] c, input logic [7:0] d);
        push_frame(c, d);
        case (c)
            2'b00: ref_waddr = d;
            2'b01: ref_mem[ref_waddr] = d;
            2'b10: begin
                ref_raddr = d;
`ifdef SPI_MASTER_AUTO_RD_EN
                push_frame(2'b11, 8'h00);
                exp_rsp.push_back(ref_mem[ref_raddr]);
`endif
            end
            default: exp_rsp.push_back(ref_mem[ref_raddr]);
        endcase
    endfunction

    // Slave model: decodes MOSI, owns its RAM, drives the reply on MISO.
    logic [7:0] s_mem [256];
    logic [7:0] s_waddr = 8'h00;
    logic [7:0] s_raddr = 8'h00;
    logic [7:0] s_reply = 8'h00;
    logic [9:0] s_fr = 10'h0;
    int         sk = -1;

    always @(posedge CLK) begin
        #1;
        if (SS_n) begin
            sk = -1;
            MISO = 1'b0;
        end else begin
            sk++;
            if (sk >= 1 && sk <= 10) s_fr = {s_fr[8:0], MOSI};
            if (sk == 10) begin
                case (s_fr[9:8])
                    2'b00: s_waddr = s_fr[7:0];
                    2'b01: s_mem[s_waddr] = s_fr[7:0];
                    2'b10: s_raddr = s_fr[7:0];
                    default: s_reply = s_mem[s_raddr];
                endcase
            end
            if (sk >= 11 + RD_WAIT && sk <= 18 + RD_WAIT)
                MISO = s_reply[7 - (sk - 11 - RD_WAIT)];
            else
                MISO = 1'b0;
        end
    end

    // Monitor: frame trace, SS_n gaps and response pulses.
    int          flen = 0;
    int          gap = 0;
    int          last_gap = -1;
    bit          seen_frame = 1'b0;
    bit          prev_v = 1'b0;
    logic [31:0] acc = '0;

    always @(negedge CLK) begin
        int          n;
        logic [31:0] b;
        logic [7:0]  e;
        if (rst) begin
            flen = 0;
            acc = '0;
            gap = 0;
            seen_frame = 1'b0;
            prev_v = 1'b0;
            exp_bits.delete();
            exp_len.delete();
            exp_rsp.delete();
        end else begin
            if (!SS_n) begin
                if (flen == 0 && seen_frame) begin
                    chk("gap_min", 32'(gap >= GAP_CYC + 1), 1);
                    last_gap = gap;
                end
                flen++;
                acc = {acc[30:0], MOSI};
            end else begin
                if (flen > 0) begin
                    if (exp_len.size() == 0) begin
                        chk("unexpected_frame", flen, 0);
                    end else begin
                        n = exp_len.pop_front();
                        b = exp_bits.pop_front();
                        chk("frame_len", flen, n);
                        chk("frame_bits", acc, b);
                    end
                    flen = 0;
                    acc = '0;
                    gap = 0;
                    seen_frame = 1'b1;
                end
                gap++;
            end
            if (rsp_valid) begin
                chk("rsp_pulse", 32'(prev_v), 0);
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", rsp_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data, e);
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] d,
                         input bit keep);
        int t;
        cmd_valid = 1'b1;
        cmd = c;
        cmd_data = d;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!cmd_ready && t < 300);
        if (!cmd_ready) begin
            chk("accept", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        model(c, d);
        @(posedge CLK);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (busy && t < 300);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_ss_n", SS_n, 1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            s_mem[i] = 8'h00;
        end
        // Reset held with a pending command: nothing may start.
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd = 2'b00;
        cmd_data = 8'h55;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_ss_n", SS_n, 1);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mosi", MOSI, 0);
            chk("rst_rsp_data", rsp_data, 0);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_ss_n", SS_n, 1);

        // Directed: wr-addr, back-to-back wr-data, then a read.
        issue(2'b00, 8'hD4, 1'b1);
        issue(2'b01, 8'hF2, 1'b0);
        wait_idle();
        chk("b2b_gap", last_gap, GAP_CYC + 1);
        issue(2'b00, 8'h10, 1'b0);
        wait_idle();
        issue(2'b01, 8'hF0, 1'b0);
        wait_idle();
        issue(2'b10, 8'h10, 1'b0);
        wait_idle();
        issue(2'b11, 8'hAC, 1'b0);
        wait_idle();
        chk("read_byte", rsp_data, 8'hF0);

        // Abort a wr-addr frame during SHIFT bit 5.
        cmd_valid = 1'b1;
        cmd = 2'b00;
        cmd_data = 8'hD4;
        @(negedge CLK);
        chk("abort_ready", cmd_ready, 1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("abort_mid_ss_n", SS_n, 0);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_ss_n", SS_n, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        @(posedge CLK);
        #1;
        issue(2'b00, 8'hD4, 1'b0);
        wait_idle();

        // Randomized command stream, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] c;
            logic [7:0] d;
            bit         k;
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            k = 1'($urandom_range(0, 1));
            issue(c, d, k);
            if (!k && $urandom_range(0, 2) == 0) wait_idle();
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge CLK);
        chk("frames_drained", exp_len.size(), 0);
        chk("rsp_drained", exp_rsp.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master that drives the team's SPI slave + single-port RAM over SS_n/MOSI/MISO using the slave's 10-bit frame: 2-bit command + 8-bit payload, MSB first.
- Accepts one command per valid/ready handshake from a host-side interface.
- For read-data commands, collects the 8-bit reply from MISO and returns it on a response port.
- Sits between the system controller/CPU and the external SPI RAM slave; same clock as the slave.

Parameters:
- RD_WAIT, 2, turnaround cycles between the last MOSI bit and the first MISO sample for a read-data frame (covers slave RAM latency + tx_valid); legal range 1..15.
- GAP_CYC, 1, cycles SS_n is held high in END after each frame; legal range 1..15.

Ports:
- CLK  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid && cmd_ready at a posedge.
- cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- cmd_data  in  8  payload (address or data; don't-care content for 11).
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  8  byte read from slave; holds until the next rsp_valid.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00; FSM to IDLE; counters to 0.
- On handshake, latch frame = {cmd, cmd_data} into a 10-bit shift register.
- FSM states: IDLE, START, SHIFT, WAIT, RECV, END.
- IDLE: SS_n=1, cmd_ready=1. On handshake -> START.
- START: 1 cycle. SS_n=0, MOSI=frame[9]; this is the slave's command-check cycle. -> SHIFT.
- SHIFT: 10 cycles. MOSI = frame[9] down to frame[0], one bit per cycle.
  - After the 10th bit: cmd==11 -> WAIT; otherwise -> END.
- WAIT: RD_WAIT cycles. SS_n=0, MOSI=0. -> RECV.
- RECV: 8 cycles. Sample MISO each posedge, MSB first, into an 8-bit shift register.
  - After the 8th sample: rsp_data updated and rsp_valid=1 in the same cycle that END is entered.
- END: GAP_CYC cycles. SS_n=1, MOSI=0. -> IDLE.
- Frame lengths (SS_n low):
  - Non-read frame: 11 cycles.
  - Read-data frame: 19+RD_WAIT cycles (21 at default).
- Minimum SS_n-high gap between back-to-back frames: GAP_CYC+1 cycles, because IDLE accepts the next command.
- cmd_valid while busy is ignored; the host must hold the command until accepted.
- rsp_valid is never asserted for cmd 00/01/10.
- rst at any cycle, including mid-SHIFT or mid-RECV: the next posedge forces all reset values. The partial frame is aborted, SS_n rises immediately, and no rsp_valid is issued.
- Counters: 4-bit bit/cycle counters, saturate-free; reload on each state entry.

Optional Feature:
- Macro: SPI_MASTER_AUTO_RD_EN.
- Defined: an accepted cmd 10 (rd-addr) automatically issues a following cmd 11 frame with payload 8'h00 after the END gap, without a host handshake.
  - cmd_ready stays low and busy stays high until the auto read completes.
  - Exactly one rsp_valid per rd-addr command.
- Undefined: cmd 10 is a plain 11-cycle frame; the host issues cmd 11 itself.

Decomposition:
- Shared package/include spi_pkg holds:
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W=10, DATA_W=8;
  - FSM state encodings.
- One natural sub-module: spi_master_shreg, holding the parallel-load MOSI shift register plus the MISO capture register with its bit counter.
- The FSM stays in spi_master_ctrl.

Test Plan:
- Reset: hold rst 2 cycles with cmd_valid=1 -> SS_n=1, cmd_ready=1, rsp_valid=0, no frame started.
- Write address cmd=00, data=8'hD4 -> SS_n low exactly 11 cycles; MOSI sequence 0,0,0,1,1,0,1,0,1,0,0; no rsp_valid; busy low after END.
- Write data cmd=01, data=8'hF2 back-to-back with a held cmd_valid -> SS_n high exactly 2 cycles between frames; second MOSI sequence 0,0,1,1,1,1,1,0,0,1,0.
- Read data cmd=11, data=8'hAC; slave model drives MISO=8'hF0 MSB first starting RD_WAIT=2 cycles after the last MOSI bit -> SS_n low 21 cycles; one rsp_valid pulse with rsp_data=8'hF0.
- Abort: assert rst during SHIFT bit 5 of a cmd=00, data=8'hD4 frame -> SS_n=1 at the next posedge; no rsp_valid; the next command runs a clean 11-cycle frame.
- With SPI_MASTER_AUTO_RD_EN: cmd=10, data=8'hD4, slave returns 8'h5A -> rd-addr frame, 2-cycle gap, auto cmd 11 frame, rsp_data=8'h5A; cmd_ready low throughout.
